// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a req/ack
// handshake and hands it to decode, discarding wrong-path fetches on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_q + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect never lets a new instruction into the buffer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          state_d = imem_ack ? S_FETCH : S_DRAIN;
        end else if (imem_ack) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect || id_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Memory request outputs; a drain keeps presenting the abandoned address until acked
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      S_FETCH: begin
        imem_req  = !rst;
        imem_addr = pc_q;
      end
      S_DRAIN: begin
        imem_req  = !rst;
        imem_addr = drain_addr_q;
      end
      S_HOLD: begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
      end
    endcase
  end

  // Datapath next-state: PC, drain address and the decode output buffer
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;
    if (redirect) begin
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      if ((state_q == S_FETCH) && !imem_ack) begin
        drain_addr_d = pc_q;
      end else begin
        drain_addr_d = drain_addr_q;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            id_instr_d = imem_rdata;
            id_pc4_d   = pc_plus4_s;
            pc_d       = pc_plus4_s;
            id_valid_d = 1'b1;
          end else begin
            id_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            id_valid_d = 1'b0;
          end else begin
            id_valid_d = 1'b1;
          end
        end
        S_DRAIN: id_valid_d = 1'b0;
        default: id_valid_d = 1'b0;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0000_0000;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0000_0000;
      id_pc4_q     <= 32'h0000_0000;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc4   = id_pc4_q;
  assign pc       = pc_q;

endmodule
